// File: rtl/sv_pattern_pkg.sv
// sv_pattern_pkg: shared types and constants for the wildcard pattern generator.
// Holds the pattern-select and FSM enums, the built-in template constants and a popcount helper.
package sv_pattern_pkg;

  typedef enum logic [1:0] {
    PAT_A,
    PAT_B,
    PAT_C,
    PAT_USER
  } pat_sel_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // 10??01??
  localparam logic [7:0] PAT_A_VALUE = 8'h84;
  localparam logic [7:0] PAT_A_MASK  = 8'h33;
  // 11??00??
  localparam logic [7:0] PAT_B_VALUE = 8'hC0;
  localparam logic [7:0] PAT_B_MASK  = 8'h33;
  // ?1?0?1?0
  localparam logic [7:0] PAT_C_VALUE = 8'h44;
  localparam logic [7:0] PAT_C_MASK  = 8'hAA;

  function automatic int unsigned popcount(
    input logic [31:0] v
  );
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/sv_bit_deposit.sv
// sv_bit_deposit: scatters the low bits of src into the set bits of mask, LSB first.
// Ports: src (packed source bits), mask (target positions), dep (deposited result).
module sv_bit_deposit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] src,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] dep
);

  logic [WIDTH-1:0] rem;

  // rem shifts right each time a mask bit consumes one source bit,
  // so the next source bit is always at rem[0].
  always_comb begin
    dep = '0;
    rem = src;
    for (int i = 0; i < WIDTH; i++) begin
      if (mask[i]) begin
        dep[i] = rem[0];
        rem    = rem >> 1;
      end
    end
  end

endmodule

// File: rtl/sv_pattern_generator.sv
// sv_pattern_generator: streams every byte matching a wildcard pattern in ascending order.
// Ports: clk, rst (sync, active-high), start, pat_sel, cfg_value, cfg_mask,
//        data_out/valid/ready stream, busy (sequence running), done (one-cycle end pulse).
module sv_pattern_generator
  import sv_pattern_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       pat_sel,
  input  logic [WIDTH-1:0] cfg_value,
  input  logic [WIDTH-1:0] cfg_mask,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             done
);

  state_e state_q;
  state_e state_d;

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] sel_value;
  logic [WIDTH-1:0] sel_mask;
  logic [WIDTH-1:0] dep_bits;
  logic [WIDTH-1:0] word;

  // One bit wider than data so a full 2^WIDTH sequence fits.
  logic [WIDTH:0] cnt_q;
  logic [WIDTH:0] n_q;
  logic [WIDTH:0] sel_n;

  logic xfer;
  logic last;

  always_comb begin
    sel_value = cfg_value;
    sel_mask  = cfg_mask;
    unique case (pat_sel_e'(pat_sel))
      PAT_A: begin
        sel_value = WIDTH'(PAT_A_VALUE);
        sel_mask  = WIDTH'(PAT_A_MASK);
      end
      PAT_B: begin
        sel_value = WIDTH'(PAT_B_VALUE);
        sel_mask  = WIDTH'(PAT_B_MASK);
      end
      PAT_C: begin
        sel_value = WIDTH'(PAT_C_VALUE);
        sel_mask  = WIDTH'(PAT_C_MASK);
      end
      PAT_USER: begin
        sel_value = cfg_value;
        sel_mask  = cfg_mask;
      end
      default: begin
        sel_value = cfg_value;
        sel_mask  = cfg_mask;
      end
    endcase
  end

  always_comb begin
    sel_n = (WIDTH+1)'(1) << popcount(32'(sel_mask));
  end

  sv_bit_deposit #(
    .WIDTH (WIDTH)
  ) u_deposit (
    .src  (cnt_q[WIDTH-1:0]),
    .mask (mask_q),
    .dep  (dep_bits)
  );

  // Fixed bits come from the latched value; wildcard bits enumerate k.
  assign word = (value_q & ~mask_q) | dep_bits;
  assign xfer = (state_q == RUN) && ready;
  assign last = (cnt_q == (n_q - (WIDTH+1)'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      value_q <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && start) begin
        value_q <= sel_value;
        mask_q  <= sel_mask;
        n_q     <= sel_n;
        cnt_q   <= '0;
      end else if (xfer && !last) begin
        cnt_q <= cnt_q + (WIDTH+1)'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    valid    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    data_out = '0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        valid    = 1'b1;
        busy     = 1'b1;
        data_out = word;
        if (ready && last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
